// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control definitions for the multicycle datapath.
// Used by multicycle_control, alu_control and the datapath top.
// Optional feature macro: CTRL_JUMP_EN (adds the JUMP state and the J opcode).
package ctrl_pkg;

  localparam int OPCODE_W = 6;

  // Supported opcodes (instruction bits [31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // aluOp encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // aluSrcB encodings
  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // pcSource encodings
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef CTRL_JUMP_EN
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_AEXEC  = 4'd8,
    S_AWB    = 4'd9,
    S_BEQ    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;
`else
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_AEXEC  = 4'd8,
    S_AWB    = 4'd9,
    S_BEQ    = 4'd10
  } state_t;
`endif

  // True when the opcode is one this controller can sequence.
  function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: legal = 1'b1;
`ifdef CTRL_JUMP_EN
      OP_J:                                    legal = 1'b1;
`endif
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing fetch/decode/execute/
// memory/writeback for the multicycle datapath.
// Optional feature macro: CTRL_JUMP_EN (J opcode decodes to the JUMP state;
// without it, J is an illegal opcode and pcSource never exceeds 01).
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           memReady,
  output logic           pcWrite,
  output logic           pcWriteCond,
  output logic           iorD,
  output logic           memRead,
  output logic           memWrite,
  output logic           irWrite,
  output logic           regDst,
  output logic           memToReg,
  output logic           regWrite,
  output logic           aluSrcA,
  output logic [1:0]     aluSrcB,
  output logic [1:0]     aluOp,
  output logic [1:0]     pcSource,
  output logic           illegalOp
);

  state_t                state_r;
  state_t                next_state_s;
  logic                  illegal_r;
  logic [OPCODE_W-1:0]   op_s;
  logic                  op_legal_s;

  assign op_s       = OPCODE_W'(opcode);
  assign op_legal_s = op_is_legal(op_s);
  assign illegalOp  = illegal_r;

  // State register; reset parks the FSM in FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sticky illegal-opcode flag, set on the edge leaving DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else if (state_r == S_DECODE && !op_legal_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Next-state logic: memReady only matters in FETCH/MEMRD/MEMWR, opcode
  // only in DECODE/MEMADR.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (memReady) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op_s)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_REXEC;
          OP_ADDI:      next_state_s = S_AEXEC;
          OP_BEQ:       next_state_s = S_BEQ;
`ifdef CTRL_JUMP_EN
          OP_J:         next_state_s = S_JUMP;
`endif
          default:      next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (op_s)
          OP_LW:   next_state_s = S_MEMRD;
          OP_SW:   next_state_s = S_MEMWR;
          default: next_state_s = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        if (memReady) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (memReady) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_REXEC: next_state_s = S_RWB;
      S_AEXEC: next_state_s = S_AWB;
      S_MEMWB, S_RWB, S_AWB, S_BEQ: next_state_s = S_FETCH;
`ifdef CTRL_JUMP_EN
      S_JUMP:  next_state_s = S_FETCH;
`endif
      default: next_state_s = S_FETCH;
    endcase
  end

  // Output decode from state; the FETCH strobes are additionally gated by
  // memReady and held low while rst is asserted.
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_REGB;
    aluOp       = ALUOP_ADD;
    pcSource    = PCSRC_ALU;
    case (state_r)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady & ~rst;
        pcWrite = memReady & ~rst;
      end
      S_DECODE: begin
        aluSrcB = SRCB_BRANCH;
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        iorD    = 1'b1;
        memRead = 1'b1;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      S_MEMWR: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
      end
      S_REXEC: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      S_AEXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_AWB: begin
        regWrite = 1'b1;
      end
      S_BEQ: begin
        aluSrcA     = 1'b1;
        aluOp       = ALUOP_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCSRC_ALUOUT;
      end
`ifdef CTRL_JUMP_EN
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = PCSRC_JUMP;
      end
`endif
      default: begin
        pcWrite = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Honours CTRL_JUMP_EN.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, aluSrcA, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSource;

  multicycle_control #(.OPW(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .illegalOp(illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase kinds of an instruction, as described in the datapath's terms.
  localparam int K_FETCH = 0, K_DECODE = 1, K_ADDR = 2, K_LOAD = 3,
                 K_LOADWB = 4, K_STORE = 5, K_REXEC = 6, K_RWB = 7,
                 K_AEXEC = 8, K_AWB = 9, K_BEQ = 10, K_JUMP = 11;

  // memRead (bit 13) and aluSrcB (bits 6:5) are unconstrained in reset.
  localparam logic [16:0] FULL_MASK  = 17'h1FFFF;
  localparam logic [16:0] RESET_MASK = 17'h1FFFF & ~17'h02060;

  logic [16:0] dut_vec;
  assign dut_vec = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                    regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp,
                    pcSource, illegalOp};

  logic [16:0] exp_vec;
  logic [16:0] exp_mask;
  string       exp_name;
  logic        chk_en;
  logic        ill_m;
  int          checks;
  int          errors;
  int          rw_cnt;
  int          mw_cnt;
  logic        last_rw_dst;
  logic        last_rw_m2r;

  function automatic logic legal_op(input logic [5:0] op);
    logic ok;
    ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
         (op == 6'b000100) || (op == 6'b001000);
`ifdef CTRL_JUMP_EN
    ok = ok || (op == 6'b000010);
`endif
    return ok;
  endfunction

  // Expected control word for one cycle of a given phase.
  function automatic logic [16:0] model(input int kind, input logic rdy, input logic ill);
    logic pw = 1'b0, pwc = 1'b0, iord = 1'b0, mr = 1'b0, mw = 1'b0, irw = 1'b0;
    logic rd = 1'b0, m2r = 1'b0, rw = 1'b0, sa = 1'b0;
    logic [1:0] sb = 2'd0, op = 2'd0, ps = 2'd0;
    case (kind)
      K_FETCH:  begin mr = 1'b1; sb = 2'd1; irw = rdy; pw = rdy; end
      K_DECODE: begin sb = 2'd3; end
      K_ADDR:   begin sa = 1'b1; sb = 2'd2; end
      K_LOAD:   begin iord = 1'b1; mr = 1'b1; end
      K_LOADWB: begin rw = 1'b1; m2r = 1'b1; end
      K_STORE:  begin iord = 1'b1; mw = 1'b1; end
      K_REXEC:  begin sa = 1'b1; op = 2'd2; end
      K_RWB:    begin rw = 1'b1; rd = 1'b1; end
      K_AEXEC:  begin sa = 1'b1; sb = 2'd2; end
      K_AWB:    begin rw = 1'b1; end
      K_BEQ:    begin sa = 1'b1; op = 2'd1; pwc = 1'b1; ps = 2'd1; end
      K_JUMP:   begin pw = 1'b1; ps = 2'd2; end
      default:  begin pw = 1'b0; end
    endcase
    return {pw, pwc, iord, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps, ill};
  endfunction

  // Compare process: checks the DUT against the expectation every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checks = checks + 1;
      if ((dut_vec & exp_mask) !== (exp_vec & exp_mask)) begin
        errors = errors + 1;
        $display("FAIL %s: got %05h want %05h (mask %05h) at %0t",
                 exp_name, dut_vec, exp_vec, exp_mask, $time);
      end
      if (regWrite) begin
        rw_cnt      = rw_cnt + 1;
        last_rw_dst = regDst;
        last_rw_m2r = memToReg;
      end
      if (memWrite) mw_cnt = mw_cnt + 1;
    end
  end

  task automatic check_lit(input string nm, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // One clock of a phase with an explicit memReady value.
  task automatic step(input int kind, input logic rdy, input string nm);
    memReady = rdy;
    exp_vec  = model(kind, rdy, ill_m);
    exp_mask = FULL_MASK;
    exp_name = nm;
    chk_en   = 1'b1;
    @(posedge clk); #1;
  endtask

  // Phase where memReady must be ignored: toggle it to prove that.
  task automatic step_ign(input int kind, input string nm);
    step(kind, ~memReady, nm);
  endtask

  task automatic step_reset(input string nm);
    memReady = 1'b1;
    exp_vec  = 17'h00000;
    exp_mask = RESET_MASK;
    exp_name = nm;
    chk_en   = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic instr(input logic [5:0] op, input int fw, input int mw);
    opcode = op;
    for (int i = 0; i <= fw; i++) step(K_FETCH, (i == fw), "fetch");
    step_ign(K_DECODE, "decode");
    if (!legal_op(op)) begin
      ill_m = 1'b1;
    end else begin
      case (op)
        6'b100011: begin
          step_ign(K_ADDR, "lw_addr");
          for (int i = 0; i <= mw; i++) step(K_LOAD, (i == mw), "lw_mem");
          step_ign(K_LOADWB, "lw_wb");
        end
        6'b101011: begin
          step_ign(K_ADDR, "sw_addr");
          for (int i = 0; i <= mw; i++) step(K_STORE, (i == mw), "sw_mem");
        end
        6'b000000: begin
          step_ign(K_REXEC, "r_exec");
          step_ign(K_RWB, "r_wb");
        end
        6'b001000: begin
          step_ign(K_AEXEC, "addi_exec");
          step_ign(K_AWB, "addi_wb");
        end
        6'b000100: step_ign(K_BEQ, "beq");
        default:   step_ign(K_JUMP, "jump");
      endcase
    end
  endtask

  int rw0, mw0;

  initial begin
    checks = 0; errors = 0; rw_cnt = 0; mw_cnt = 0;
    last_rw_dst = 1'b0; last_rw_m2r = 1'b0;
    chk_en = 1'b0; ill_m = 1'b0; opcode = 6'd0; memReady = 1'b1;
    exp_vec = 17'h0; exp_mask = FULL_MASK; exp_name = "idle";
    rst = 1'b1;
    #1;
    repeat (3) step_reset("reset");
    rst = 1'b0;

    // RTYPE: write to rd in its 4th cycle
    rw0 = rw_cnt;
    instr(6'b000000, 0, 0);
    check_lit("rtype_rw_count", rw_cnt - rw0, 1);
    check_lit("rtype_regdst", int'(last_rw_dst), 1);

    // LW with two memory wait cycles (7 cycles)
    rw0 = rw_cnt;
    instr(6'b100011, 0, 2);
    check_lit("lw_rw_count", rw_cnt - rw0, 1);
    check_lit("lw_memtoreg", int'(last_rw_m2r), 1);

    // SW with one wait: memWrite two cycles, no register write
    rw0 = rw_cnt; mw0 = mw_cnt;
    instr(6'b101011, 0, 1);
    check_lit("sw_mw_cycles", mw_cnt - mw0, 2);
    check_lit("sw_rw_count", rw_cnt - rw0, 0);

    // BEQ then ADDI (ADDI with one fetch wait)
    instr(6'b000100, 0, 0);
    instr(6'b001000, 1, 0);

    // Unsupported opcode: back to FETCH after 2 cycles, sticky flag
    instr(6'b111111, 0, 0);
    check_lit("illegal_set", int'(illegalOp), 1);
    instr(6'b000000, 1, 0);
    check_lit("illegal_sticky", int'(illegalOp), 1);

    // Reset in the middle of a store
    mw0 = mw_cnt;
    opcode = 6'b101011;
    step(K_FETCH, 1'b1, "fetch");
    step_ign(K_DECODE, "decode");
    step_ign(K_ADDR, "sw_addr");
    step(K_STORE, 1'b0, "sw_mem");
    check_lit("sw_memwrite_before_rst", int'(memWrite), 1);
    rst = 1'b1;
    #1;
    check_lit("sw_memwrite_at_rst", int'(memWrite), 0);
    ill_m = 1'b0;
    exp_vec = 17'h0; exp_mask = RESET_MASK; exp_name = "rst_mid";
    @(posedge clk); #1;
    step_reset("rst_mid");
    rst = 1'b0;
    check_lit("illegal_cleared", int'(illegalOp), 0);
    check_lit("sw_abort_mw_cycles", mw_cnt - mw0, 1);
    instr(6'b000000, 0, 0);

    // J: decodes to JUMP only with the jump feature
    instr(6'b000010, 0, 0);
`ifdef CTRL_JUMP_EN
    check_lit("j_illegal", int'(illegalOp), 0);
`else
    check_lit("j_illegal", int'(illegalOp), 1);
`endif
    instr(6'b001000, 0, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
